// File: rtl/seg_pkg.sv
// seg_pkg: shared types and helpers for the segment scan controller.
// Holds the prescaler divide helper, index-width helper, FSM state encoding
// and the all-anodes-off pattern used by seg_scan_ctrl.
package seg_pkg;

    // Scan controller states; BLANK is only reachable with GHOST_BLANK_EN.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        BLANK = 2'd2
    } seg_state_e;

    // Anode pattern with every digit dark (active-low lines); slice to width.
    localparam logic [31:0] AN_ALL_OFF = 32'hFFFF_FFFF;

    // Clock cycles per digit dwell.
    function automatic int tick_div(input int clk_hz, input int scan_hz);
        return clk_hz / scan_hz;
    endfunction

    // Width of a digit index; a single digit still gets one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg_scan_tick.sv
// seg_scan_tick: dwell prescaler. Counts 0..DIV-1 and flags the last count.
// clear_i forces the count to zero, hold_i freezes it (used while blanking).
module seg_scan_tick #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic hold_i,
    output logic tick_o
);
    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == LAST) && !hold_i && !clear_i;

    // Next count: clear beats hold, otherwise wrap at the last count.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (hold_i) begin
            cnt_d = cnt_q;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexes NUM_DIGITS BCD digits onto one shared decoder
// and a common-anode display, with leading-zero suppression and tear-free
// digit-set updates. Define GHOST_BLANK_EN to insert an anode-off gap of
// BLANK_CYCLES cycles between digit dwells.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int  CLK_HZ       = 100000000,
    parameter int  SCAN_HZ      = 1000,
    parameter int  NUM_DIGITS   = 4,
    parameter int  BLANK_CYCLES = 16,
    localparam int IW           = idx_w(NUM_DIGITS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    lz_suppress,
    input  logic                    upd_valid,
    output logic                    upd_ready,
    input  logic [4*NUM_DIGITS-1:0] upd_digits,
    output logic [3:0]              digit_bcd,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic [IW-1:0]           digit_idx,
    output logic                    frame_done,
    output logic [1:0]              state_dbg
);
    localparam int            TICK_DIV = tick_div(CLK_HZ, SCAN_HZ);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

    if (TICK_DIV < 2 || BLANK_CYCLES < 1) begin : g_param_check
        $error("seg_scan_ctrl: TICK_DIV must be >= 2 and BLANK_CYCLES >= 1");
    end

    seg_state_e                state_q, state_d;
    logic [IW-1:0]             idx_q, idx_d, idx_next;
    logic                      at_last, tick, wrap;
    logic [4*NUM_DIGITS-1:0]   active_q, active_d, shadow_q, shadow_d;
    logic                      pending_q, pending_d, capture, commit;
    logic [NUM_DIGITS-1:0]     suppress, an_n_q, an_n_d;
    logic                      all_zero;
    logic [3:0]                bcd_q, bcd_d;
    logic                      frame_done_q, frame_done_d;

    seg_scan_tick #(.DIV(TICK_DIV)) u_tick (
        .clk     (clk),
        .rst     (rst),
        .clear_i ((state_q == IDLE) || !en),
        .hold_i  (state_q == BLANK),
        .tick_o  (tick)
    );

    assign at_last  = (idx_q == LAST_IDX);
    assign idx_next = at_last ? '0 : idx_q + IW'(1);

`ifdef GHOST_BLANK_EN
    localparam int            BW         = $clog2(BLANK_CYCLES + 1);
    localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);
    logic [BW-1:0] blank_q, blank_d;

    // Gap counter, restarts from zero on every entry to BLANK.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blank_q <= '0;
        end else begin
            blank_q <= blank_d;
        end
    end
`endif

    // Next state / index; wrap marks the last digit's dwell ending.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wrap    = 1'b0;
`ifdef GHOST_BLANK_EN
        blank_d = '0;
`endif
        if (!en) begin
            state_d = IDLE;
            idx_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = SCAN;
                    idx_d   = '0;
                end
                SCAN: begin
                    if (tick) begin
`ifdef GHOST_BLANK_EN
                        state_d = BLANK;
`else
                        wrap  = at_last;
                        idx_d = idx_next;
`endif
                    end
                end
                BLANK: begin
`ifdef GHOST_BLANK_EN
                    if (blank_q == BLANK_LAST) begin
                        state_d = SCAN;
                        wrap    = at_last;
                        idx_d   = idx_next;
                    end else begin
                        blank_d = blank_q + BW'(1);
                    end
`else
                    state_d = IDLE;
`endif
                end
                default: state_d = IDLE;
            endcase
        end
        frame_done_d = wrap;
    end

    // Handshake: a set transfers on a cycle with upd_valid & upd_ready; the
    // producer holds upd_valid and upd_digits stable until that cycle.
    // upd_ready is low while a captured set waits in the shadow register.
    // The shadow commits on a frame wrap (or immediately when idle), so a
    // capture on the wrap cycle itself waits for the following wrap.
    assign upd_ready = ~pending_q;
    assign capture   = upd_valid & ~pending_q;
    assign commit    = pending_q & ((state_q == IDLE) | wrap);

    // Shadow/active/pending next values.
    always_comb begin
        active_d  = active_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        if (commit) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
        if (capture) begin
            shadow_d  = upd_digits;
            pending_d = 1'b1;
        end
    end

    // Leading-zero mask: digit i>0 hides when it and all higher digits are 0.
    always_comb begin
        suppress = '0;
        all_zero = lz_suppress;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            all_zero    = all_zero & (active_q[4*i +: 4] == 4'd0);
            suppress[i] = all_zero;
        end
    end

    // Display outputs computed from the current state/index.
    always_comb begin
        an_n_d = AN_ALL_OFF[NUM_DIGITS-1:0];
        if (en && (state_q == SCAN) && !suppress[idx_q]) begin
            an_n_d[idx_q] = 1'b0;
        end
        bcd_d = active_q[{idx_q, 2'b00} +: 4];
    end

    // All state and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            active_q     <= '0;
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            an_n_q       <= AN_ALL_OFF[NUM_DIGITS-1:0];
            bcd_q        <= 4'd0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            active_q     <= active_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            an_n_q       <= an_n_d;
            bcd_q        <= bcd_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign digit_bcd  = bcd_q;
    assign an_n       = an_n_q;
    assign digit_idx  = idx_q;
    assign frame_done = frame_done_q;
    assign state_dbg  = state_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: self-checking bench for seg_scan_ctrl. The reference
// model tracks the cycle count since scanning started and derives digit,
// blanking and frame position arithmetically. Define GHOST_BLANK_EN to build
// both bench and design with the blanking gap.
`timescale 1ns/1ps
module tb_seg_scan_ctrl;
    localparam int CLK_HZ = 1000;
    localparam int SCAN_HZ = 250;
    localparam int ND = 4;
    localparam int BC = 2;
    localparam int TD = CLK_HZ / SCAN_HZ;
    localparam int IW = 2;
`ifdef GHOST_BLANK_EN
    localparam int SLOT = TD + BC;
`else
    localparam int SLOT = TD;
`endif
    localparam int FRAME = SLOT * ND;

    // Clock/reset and DUT signals
    logic            clk = 1'b0;
    logic            rst, en, lz_suppress, upd_valid;
    logic            upd_ready, frame_done;
    logic [4*ND-1:0] upd_digits;
    logic [3:0]      digit_bcd;
    logic [ND-1:0]   an_n;
    logic [IW-1:0]   digit_idx;
    logic [1:0]      state_dbg;

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .NUM_DIGITS(ND), .BLANK_CYCLES(BC)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .lz_suppress(lz_suppress),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_digits(upd_digits),
        .digit_bcd(digit_bcd), .an_n(an_n), .digit_idx(digit_idx),
        .frame_done(frame_done), .state_dbg(state_dbg)
    );

    int total, bad;

    // Reference model: m_k = cycles since scanning began, -1 when idle
    int              m_k;
    logic [4*ND-1:0] m_act, m_sh;
    bit              m_pend, m_took;
    logic [ND-1:0]   e_an;
    logic [3:0]      e_bcd;
    logic [IW-1:0]   e_idx;
    logic            e_fd, e_rdy;

    function automatic int slot_digit(input int k);
        return (k / SLOT) % ND;
    endfunction

    function automatic bit in_blank(input int k);
        return (k % SLOT) >= TD;
    endfunction

    function automatic bit lz_hidden(input logic [4*ND-1:0] digs, input int d);
        if (d == 0) return 1'b0;
        for (int j = d; j < ND; j++) if (digs[4*j +: 4] != 4'h0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_k = -1; m_act = '0; m_sh = '0; m_pend = 1'b0; m_took = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs present at the edge.
    task automatic model_step();
        int kp, dp;
        logic [4*ND-1:0] act_p;
        bit pend_p;
        kp = m_k; act_p = m_act; pend_p = m_pend; m_took = 1'b0;
        if (pend_p && (kp < 0 || (en && ((kp + 1) % FRAME == 0)))) begin
            m_act = m_sh; m_pend = 1'b0;
        end
        if (upd_valid && !pend_p) begin
            m_sh = upd_digits; m_pend = 1'b1; m_took = 1'b1;
        end
        m_k = en ? kp + 1 : -1;
        dp = (kp < 0) ? 0 : slot_digit(kp);
        e_bcd = act_p[4*dp +: 4];
        e_an = '1;
        if (en && kp >= 0 && !in_blank(kp) && !(lz_suppress && lz_hidden(act_p, dp)))
            e_an[dp] = 1'b0;
        e_idx = (m_k < 0) ? '0 : IW'(slot_digit(m_k));
        e_fd = (m_k > 0) && (m_k % FRAME == 0);
        e_rdy = !m_pend;
    endtask

    task automatic test_reset();
        #3;
        total++;
        if ({an_n, digit_bcd, digit_idx, frame_done, upd_ready} !== {4'b1111, 4'h0, 2'd0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL rst_init got an=%b bcd=%0d idx=%0d fd=%b rdy=%b want an=1111 bcd=0 idx=0 fd=0 rdy=1",
                     an_n, digit_bcd, digit_idx, frame_done, upd_ready);
        end
        @(posedge clk); #1; rst = 1'b0;
        upd_valid = 1'b1; upd_digits = 16'h4321;
        for (int c = 0; c < 14; c++) begin
            @(posedge clk); model_step(); #1;
            total++;
            if ({an_n, digit_bcd, digit_idx, frame_done, upd_ready} !== {e_an, e_bcd, e_idx, e_fd, e_rdy}) begin
                bad++;
                $display("FAIL rst_run c=%0d got an=%b bcd=%0d idx=%0d fd=%b rdy=%b want an=%b bcd=%0d idx=%0d fd=%b rdy=%b",
                         c, an_n, digit_bcd, digit_idx, frame_done, upd_ready, e_an, e_bcd, e_idx, e_fd, e_rdy);
            end
            if (m_took) upd_valid = 1'b0;
            if (c == 3) en = 1'b1;
        end
        // asynchronous reset in the middle of a dwell
        #2; rst = 1'b1; en = 1'b0;
        #1; model_reset();
        for (int c = 0; c < 3; c++) begin
            total++;
            if ({an_n, digit_bcd, digit_idx, frame_done, upd_ready} !== {4'b1111, 4'h0, 2'd0, 1'b0, 1'b1}) begin
                bad++;
                $display("FAIL rst_mid c=%0d got an=%b bcd=%0d idx=%0d fd=%b rdy=%b want an=1111 bcd=0 idx=0 fd=0 rdy=1",
                         c, an_n, digit_bcd, digit_idx, frame_done, upd_ready);
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;
    endtask

    task automatic test_scan();
        int last_fd, n_fd;
        last_fd = -1; n_fd = 0;
        upd_valid = 1'b1; upd_digits = 16'h4321;
        for (int c = 0; c < 3 * FRAME + 6; c++) begin
            @(posedge clk); model_step(); #1;
            total++;
            if ({an_n, digit_bcd, digit_idx, frame_done, upd_ready} !== {e_an, e_bcd, e_idx, e_fd, e_rdy}) begin
                bad++;
                $display("FAIL scan c=%0d got an=%b bcd=%0d idx=%0d fd=%b rdy=%b want an=%b bcd=%0d idx=%0d fd=%b rdy=%b",
                         c, an_n, digit_bcd, digit_idx, frame_done, upd_ready, e_an, e_bcd, e_idx, e_fd, e_rdy);
            end
            for (int d = 0; d < ND; d++) begin
                logic [ND-1:0] one_low;
                one_low = ~(ND'(1) << d);
                if (an_n === one_low) begin
                    total++;
                    if (digit_bcd !== 4'(d + 1)) begin
                        bad++;
                        $display("FAIL scan_bcd digit=%0d got %0d want %0d", d, digit_bcd, d + 1);
                    end
                end
            end
            if (frame_done === 1'b1) begin
                n_fd++;
                if (last_fd >= 0) begin
                    total++;
                    if (c - last_fd != FRAME) begin
                        bad++;
                        $display("FAIL scan_period got %0d want %0d", c - last_fd, FRAME);
                    end
                end
                last_fd = c;
            end
            if (m_took) upd_valid = 1'b0;
            if (c == 2) en = 1'b1;
        end
        total++;
        if (n_fd < 3) begin
            bad++;
            $display("FAIL scan_fd_count got %0d want >=3", n_fd);
        end
    endtask

    task automatic test_handshake();
        int ph;
        ph = 0;
        for (int c = 0; c < 5 * FRAME && ph < 3; c++) begin
            if (ph == 0 && m_k >= 0 && (m_k % FRAME) == 6) begin
                upd_valid = 1'b1; upd_digits = 16'h5678; ph = 1;
            end
            @(posedge clk); model_step(); #1;
            total++;
            if ({an_n, digit_bcd, digit_idx, frame_done, upd_ready} !== {e_an, e_bcd, e_idx, e_fd, e_rdy}) begin
                bad++;
                $display("FAIL hs c=%0d got an=%b bcd=%0d idx=%0d fd=%b rdy=%b want an=%b bcd=%0d idx=%0d fd=%b rdy=%b",
                         c, an_n, digit_bcd, digit_idx, frame_done, upd_ready, e_an, e_bcd, e_idx, e_fd, e_rdy);
            end
            if (ph == 1) begin
                total++;
                if (upd_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL hs_accept got rdy=%b want 0", upd_ready);
                end
                upd_digits = 16'h1111; ph = 2;
            end else if (ph == 2 && m_took) begin
                upd_valid = 1'b0; ph = 3;
            end
        end
        total++;
        if (ph != 3) begin
            bad++;
            $display("FAIL hs_timeout got phase=%0d want 3", ph);
            upd_valid = 1'b0;
        end
    endtask

    task automatic test_simultaneous();
        int ph, cap_c;
        ph = 0; cap_c = 0;
        for (int c = 0; c < 6 * FRAME && ph < 3; c++) begin
            if (ph == 0 && !m_pend && m_k >= 0 && (m_k % FRAME) == FRAME - 1) begin
                upd_valid = 1'b1; upd_digits = 16'h2468; ph = 1; cap_c = c;
            end
            @(posedge clk); model_step(); #1;
            total++;
            if ({an_n, digit_bcd, digit_idx, frame_done, upd_ready} !== {e_an, e_bcd, e_idx, e_fd, e_rdy}) begin
                bad++;
                $display("FAIL simul c=%0d got an=%b bcd=%0d idx=%0d fd=%b rdy=%b want an=%b bcd=%0d idx=%0d fd=%b rdy=%b",
                         c, an_n, digit_bcd, digit_idx, frame_done, upd_ready, e_an, e_bcd, e_idx, e_fd, e_rdy);
            end
            if (ph == 1) begin
                total++;
                if ({frame_done, upd_ready} !== 2'b10) begin
                    bad++;
                    $display("FAIL simul_wrap got fd=%b rdy=%b want fd=1 rdy=0", frame_done, upd_ready);
                end
                upd_valid = 1'b0; ph = 2;
            end else if (ph == 2 && c == cap_c + 1) begin
                total++;
                if (digit_bcd !== 4'h1) begin
                    bad++;
                    $display("FAIL simul_old got %0d want 1", digit_bcd);
                end
            end else if (ph == 2 && c == cap_c + FRAME + 1) begin
                total++;
                if (digit_bcd !== 4'h8) begin
                    bad++;
                    $display("FAIL simul_new got %0d want 8", digit_bcd);
                end
                ph = 3;
            end
        end
        total++;
        if (ph != 3) begin
            bad++;
            $display("FAIL simul_timeout got phase=%0d want 3", ph);
            upd_valid = 1'b0;
        end
    endtask

    task automatic test_lz();
        logic [4*ND-1:0] pats [4];
        logic [ND-1:0]   masks [4];
        logic [4*ND-1:0] pat;
        logic [ND-1:0]   lit;
        int ph, n;
        pats[0] = 16'h0090; masks[0] = 4'b0011;
        pats[1] = 16'h0000; masks[1] = 4'b0001;
        pats[2] = 16'h00A0; masks[2] = 4'b0011;
        pats[3] = 16'h0905; masks[3] = 4'b0111;
        lz_suppress = 1'b1;
        for (int p = 0; p < 4; p++) begin
            pat = pats[p]; lit = '0; ph = 0; n = 0;
            upd_valid = 1'b1; upd_digits = pat;
            for (int c = 0; c < 5 * FRAME && ph < 3; c++) begin
                @(posedge clk); model_step(); #1;
                total++;
                if ({an_n, digit_bcd, digit_idx, frame_done, upd_ready} !== {e_an, e_bcd, e_idx, e_fd, e_rdy}) begin
                    bad++;
                    $display("FAIL lz p=%0d c=%0d got an=%b bcd=%0d idx=%0d fd=%b rdy=%b want an=%b bcd=%0d idx=%0d fd=%b rdy=%b",
                             p, c, an_n, digit_bcd, digit_idx, frame_done, upd_ready, e_an, e_bcd, e_idx, e_fd, e_rdy);
                end
                case (ph)
                    0: if (m_took) begin upd_valid = 1'b0; ph = 1; end
                    1: if (!m_pend) ph = 2;
                    default: begin
                        lit = lit | ~an_n;
                        if (an_n === 4'b1101) begin
                            total++;
                            if (digit_bcd !== pat[7:4]) begin
                                bad++;
                                $display("FAIL lz_d1 p=%0d got %0d want %0d", p, digit_bcd, pat[7:4]);
                            end
                        end
                        n++;
                        if (n == FRAME) ph = 3;
                    end
                endcase
            end
            total++;
            if (ph != 3 || lit !== masks[p]) begin
                bad++;
                $display("FAIL lz_mask p=%0d got lit=%b phase=%0d want lit=%b", p, lit, ph, masks[p]);
                upd_valid = 1'b0;
            end
        end
        lz_suppress = 1'b0;
    endtask

    task automatic test_disable();
        int ph, n, dwell;
        ph = 0; n = 0; dwell = 0;
        for (int c = 0; c < 6 * FRAME && ph < 4; c++) begin
            if (ph == 0 && m_k >= 0 && (m_k % SLOT) == 1) begin
                en = 1'b0; ph = 1;
            end
            @(posedge clk); model_step(); #1;
            total++;
            if ({an_n, digit_bcd, digit_idx, frame_done, upd_ready} !== {e_an, e_bcd, e_idx, e_fd, e_rdy}) begin
                bad++;
                $display("FAIL dis c=%0d got an=%b bcd=%0d idx=%0d fd=%b rdy=%b want an=%b bcd=%0d idx=%0d fd=%b rdy=%b",
                         c, an_n, digit_bcd, digit_idx, frame_done, upd_ready, e_an, e_bcd, e_idx, e_fd, e_rdy);
            end
            case (ph)
                1: begin
                    total++;
                    if ({an_n, digit_idx} !== {4'b1111, 2'd0}) begin
                        bad++;
                        $display("FAIL dis_off got an=%b idx=%0d want an=1111 idx=0", an_n, digit_idx);
                    end
                    ph = 2;
                end
                2: begin
                    n++;
                    if (n == 3) begin en = 1'b1; ph = 3; n = 0; end
                end
                3: begin
                    n++;
                    if (n >= 2) begin
                        if (an_n === 4'b1110) dwell++;
                        else ph = 4;
                    end
                end
                default: ;
            endcase
        end
        total++;
        if (ph != 4 || dwell != TD) begin
            bad++;
            $display("FAIL dis_dwell got dwell=%0d phase=%0d want dwell=%0d", dwell, ph, TD);
        end
        en = 1'b1;
    endtask

    task automatic test_random();
        for (int c = 0; c < 700; c++) begin
            if ($urandom_range(0, 39) == 0) en = ~en;
            lz_suppress = 1'($urandom_range(0, 1));
            if (!upd_valid && $urandom_range(0, 5) == 0) begin
                upd_valid = 1'b1; upd_digits = 16'($urandom);
            end
            @(posedge clk); model_step(); #1;
            total++;
            if ({an_n, digit_bcd, digit_idx, frame_done, upd_ready} !== {e_an, e_bcd, e_idx, e_fd, e_rdy}) begin
                bad++;
                $display("FAIL rand c=%0d got an=%b bcd=%0d idx=%0d fd=%b rdy=%b want an=%b bcd=%0d idx=%0d fd=%b rdy=%b",
                         c, an_n, digit_bcd, digit_idx, frame_done, upd_ready, e_an, e_bcd, e_idx, e_fd, e_rdy);
            end
            if (m_took) upd_valid = 1'b0;
            if (c == 350) begin
                #2; rst = 1'b1; upd_valid = 1'b0;
                #1; model_reset();
                total++;
                if ({an_n, frame_done, upd_ready} !== {4'b1111, 1'b0, 1'b1}) begin
                    bad++;
                    $display("FAIL rand_rst got an=%b fd=%b rdy=%b want an=1111 fd=0 rdy=1", an_n, frame_done, upd_ready);
                end
                @(negedge clk); rst = 1'b0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0; bad = 0;
        rst = 1'b1; en = 1'b0; lz_suppress = 1'b0; upd_valid = 1'b0; upd_digits = '0;
        model_reset();
        test_reset();
        test_scan();
        test_handshake();
        test_simultaneous();
        test_lz();
        test_disable();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexes NUM_DIGITS BCD digits onto one shared BCD-to-7-segment decoder and the board's common-anode display.
- Sits between the egg-timer countdown logic (producer of digit values) and the decoder.
- Drives the decoder's 4-bit input and the active-low anode lines.
- Accepts new digit sets through a valid/ready handshake; a new set takes effect only at frame boundaries, so no partial-frame tearing is visible.

Parameters:
- CLK_HZ, 100000000, system clock frequency.
- SCAN_HZ, 1000, per-digit dwell rate; TICK_DIV = CLK_HZ/SCAN_HZ, must be >= 2.
- NUM_DIGITS, 4, number of multiplexed digits; digit 0 is least significant.
- BLANK_CYCLES, 16, anode-off gap per digit switch; used only with GHOST_BLANK_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- en  in  1  display enable
- lz_suppress  in  1  leading-zero suppression enable
- upd_valid  in  1  new digit set offered
- upd_ready  out  1  controller can accept a digit set
- upd_digits  in  4*NUM_DIGITS  packed BCD, digit i at [4i+3:4i]
- digit_bcd  out  4  BCD value to the shared decoder
- an_n  out  NUM_DIGITS  anode enables, active-low
- digit_idx  out  clog2(NUM_DIGITS)  index of the digit being driven
- frame_done  out  1  one-cycle pulse when the last digit's dwell ends

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - State IDLE, tick counter 0, digit_idx 0.
  - Active and shadow digit registers all 0; pending 0.
  - an_n all ones, digit_bcd 0, frame_done 0, upd_ready 1.
- Tick counter:
  - Counts 0..TICK_DIV-1 while not IDLE; tick asserts when the count is TICK_DIV-1, then wraps to 0.
  - Cleared whenever in IDLE.
- State machine:
  - IDLE: an_n all ones. Goes to SCAN when en=1; first dwell is digit 0.
  - SCAN: on tick, digit_idx increments modulo NUM_DIGITS. On wrap from NUM_DIGITS-1 to 0, frame_done pulses for exactly 1 cycle, registered with the index change.
  - Any state with en=0: go to IDLE next cycle; digit_idx resets to 0; an_n all ones.
- Outputs (all registered, one cycle behind the state/index):
  - digit_bcd = active[digit_idx].
  - an_n = only bit digit_idx low, unless that digit is suppressed.
- Leading-zero suppression (lz_suppress=1): digit i>0 is suppressed when it and every more-significant digit equal 0. Digit 0 is never suppressed.
- Values 10..15 pass to the decoder unchanged and are never treated as zero.
- Update handshake:
  - upd_ready = ~pending. A transfer occurs on upd_valid & upd_ready: upd_digits goes to shadow and pending is set.
  - Commit (shadow to active, pending cleared) happens on the frame-wrap cycle.
  - In IDLE, commit happens the cycle after capture.
  - Capture and frame-wrap in the same cycle: capture wins; commit waits for the next wrap.
  - upd_ready reasserts the cycle after commit.
- Rst mid-frame or mid-handshake: any pending shadow is discarded; all registers return to reset values immediately.

Optional Feature:
- Macro: GHOST_BLANK_EN.
- Defined: on each tick, SCAN goes to BLANK. BLANK holds an_n all ones for BLANK_CYCLES cycles, then advances digit_idx and returns to SCAN. The tick counter is held during BLANK, and frame_done pulses on the BLANK exit that wraps the index.
- Undefined: there is no BLANK state; digit_idx advances directly on tick.

Decomposition:
- Shared package seg_pkg:
  - Derived TICK_DIV and index-width functions.
  - State enumeration IDLE/SCAN/BLANK.
  - AN_ALL_OFF constant.
- One sub-module, seg_scan_tick: parameterised prescaler with hold and clear inputs and a tick output.
- The decoder stays outside this block; the top level wires digit_bcd to it.

Test Plan (CLK_HZ=1000, SCAN_HZ=250, so TICK_DIV=4; NUM_DIGITS=4):
- Reset and scan: assert rst mid-scan, then release with en=1 and active digits 4321 → an_n 1111 during reset; afterwards an_n sequences 1110, 1101, 1011, 0111 with 4-cycle dwells, digit_bcd sequences 1, 2, 3, 4, and frame_done fires every 16 cycles.
- Handshake: offer 0x5678 mid-frame → accepted in 1 cycle and upd_ready drops; digits stay 4321 until the wrap, then 8, 7, 6, 5 appear; upd_ready returns 1 cycle after the wrap; a second offer during pending is stalled.
- Simultaneous event: upd_valid on the exact wrap cycle → the new set is shown only after the following wrap (16 cycles later).
- Leading zeros: digits 0x0090 with lz_suppress=1 → digits 3 and 2 show an_n bit high, digits 1 and 0 are driven; 0x0000 → only digit 0 lit; 0x00A0 → digit 1 lit showing 10.
- Disable: drop en mid-dwell → an_n 1111 next cycle and digit_idx 0; re-enable → restarts at digit 0 with a full 4-cycle dwell.
- GHOST_BLANK_EN with BLANK_CYCLES=2 → 2-cycle an_n 1111 gap between each 4-cycle dwell; frame period 24 cycles.
